// File: rtl/dct2d_ctrl_if.sv
// Handshake and datapath bundle between dct2d_ctrl, its block source,
// the shared dct1d unit and the downstream quantiser.
interface dct2d_ctrl_if #(
  parameter int unsigned N = 16
);
  localparam int unsigned VW = 8 * N;

  logic          in_valid;
  logic          in_ready;
  logic [VW-1:0] in_data;
  logic [VW-1:0] dct_in;
  logic [VW-1:0] dct_out;
  logic          out_valid;
  logic          out_ready;
  logic [VW-1:0] out_data;
  logic          busy;
  logic          done;

  // Controller side
  modport slave (
    input  in_valid, in_data, dct_out, out_ready,
    output in_ready, dct_in, out_valid, out_data, busy, done
  );

  // Environment side (source, dct1d, sink)
  modport master (
    output in_valid, in_data, dct_out, out_ready,
    input  in_ready, dct_in, out_valid, out_data, busy, done
  );
endinterface

// File: rtl/dct2d_ctrl.sv
// 8x8 2-D DCT sequencer: loads 8 rows, runs a row pass then a column pass
// through one external 1-D DCT unit, storing results in place, then streams
// the 8 result rows out.
module dct2d_ctrl #(
  parameter int unsigned N       = 16,
  parameter int unsigned DCT_LAT = 0
) (
  input logic         clk,
  input logic         rst_n,
  dct2d_ctrl_if.slave bus
);

  localparam int unsigned VW = 8 * N;
  localparam int unsigned PW = (DCT_LAT > 0) ? $clog2(DCT_LAT + 1) : 1;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    ROW  = 2'd1,
    COL  = 2'd2,
    OUT  = 2'd3
  } state_t;

  state_t        state;
  logic [2:0]    cnt;
  logic [PW-1:0] ph;
  logic [N-1:0]  mem [8][8];

  logic [2:0]    nxt;
  logic          capture;
  logic          in_hs;
  logic [VW-1:0] row_nxt;
  logic [VW-1:0] col_nxt;
  logic [VW-1:0] out_first;

  assign nxt     = cnt + 3'd1;
  assign capture = (ph == PW'(DCT_LAT));
  assign in_hs   = (state == LOAD) && bus.in_valid && bus.in_ready;

  // Next vector to issue/emit; the buffer entry written on the same edge is
  // forwarded straight from dct_out (row 7 -> column 0, column 7 -> out row 0).
  always_comb begin
    row_nxt   = '0;
    col_nxt   = '0;
    out_first = '0;
    for (int k = 0; k < 8; k++) begin
      row_nxt[k*N +: N] = mem[nxt][3'(k)];
      if (state == ROW)
        col_nxt[k*N +: N] = (k == 7) ? bus.dct_out[N-1:0] : mem[3'(k)][0];
      else
        col_nxt[k*N +: N] = mem[3'(k)][nxt];
      out_first[k*N +: N] = (k == 7) ? bus.dct_out[N-1:0] : mem[0][3'(k)];
    end
  end

  // Block buffer: input rows, row-pass results and column-pass results in place
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (in_hs) begin
        for (int k = 0; k < 8; k++)
          mem[cnt][3'(k)] <= bus.in_data[k*N +: N];
      end else if (state == ROW && capture) begin
        for (int k = 0; k < 8; k++)
          mem[cnt][3'(k)] <= bus.dct_out[k*N +: N];
      end else if (state == COL && capture) begin
        for (int k = 0; k < 8; k++)
          mem[3'(k)][cnt] <= bus.dct_out[k*N +: N];
      end
    end
  end

  // Sequencer state, counters and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= LOAD;
      cnt           <= '0;
      ph            <= '0;
      bus.in_ready  <= 1'b1;
      bus.out_valid <= 1'b0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.dct_in    <= '0;
      bus.out_data  <= '0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        LOAD: begin
          if (in_hs) begin
            cnt <= nxt;
            if (cnt == 3'd7) begin
              state        <= ROW;
              ph           <= '0;
              bus.in_ready <= 1'b0;
              bus.busy     <= 1'b1;
              bus.dct_in   <= row_nxt;
            end
          end
        end
        ROW: begin
          if (capture) begin
            ph  <= '0;
            cnt <= nxt;
            if (cnt == 3'd7) begin
              state      <= COL;
              bus.dct_in <= col_nxt;
            end else begin
              bus.dct_in <= row_nxt;
            end
          end else begin
            ph <= ph + PW'(1);
          end
        end
        COL: begin
          if (capture) begin
            ph  <= '0;
            cnt <= nxt;
            if (cnt == 3'd7) begin
              state         <= OUT;
              bus.dct_in    <= '0;
              bus.out_valid <= 1'b1;
              bus.out_data  <= out_first;
            end else begin
              bus.dct_in <= col_nxt;
            end
          end else begin
            ph <= ph + PW'(1);
          end
        end
        OUT: begin
          if (bus.out_ready) begin
            cnt <= nxt;
            if (cnt == 3'd7) begin
              state         <= LOAD;
              bus.out_valid <= 1'b0;
              bus.busy      <= 1'b0;
              bus.done      <= 1'b1;
              bus.in_ready  <= 1'b1;
            end else begin
              bus.out_data <= row_nxt;
            end
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_dct2d_ctrl.sv
// Bench for dct2d_ctrl: two instances (dct1d latency 0 and 2) with stub
// dct1d models; expected result rows are queued when a block is sent and
// compared as the DUT emits them.
`timescale 1ns/1ps
module tb_dct2d_ctrl;

  localparam int unsigned N  = 16;
  localparam int unsigned VW = 8 * N;

  typedef logic [VW-1:0] row_t;
  typedef logic [N-1:0]  blk_t [8][8];

  logic       clk = 1'b0;
  logic       rst_n;
  logic       vld  [2];
  row_t       din  [2];
  logic       ordy [2];
  logic [1:0] mode [2];

  always #5 clk = ~clk;

  dct2d_ctrl_if #(.N(N)) if0 ();
  dct2d_ctrl_if #(.N(N)) if1 ();

  dct2d_ctrl #(.N(N), .DCT_LAT(0)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));
  dct2d_ctrl #(.N(N), .DCT_LAT(2)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));

  // Stub dct1d: 0 identity, 1 keep element 0 only, 2 add 3 per element
  function automatic row_t stub_f(input logic [1:0] m, input row_t v);
    row_t r;
    r = '0;
    case (m)
      2'd0:    r = v;
      2'd1:    r[N-1:0] = v[N-1:0];
      default: for (int k = 0; k < 8; k++) r[k*N +: N] = v[k*N +: N] + N'(3);
    endcase
    return r;
  endfunction

  assign if0.in_valid  = vld[0];
  assign if0.in_data   = din[0];
  assign if0.out_ready = ordy[0];
  assign if0.dct_out   = stub_f(mode[0], if0.dct_in);

  row_t p0, p1;
  always @(posedge clk) begin
    p0 <= stub_f(mode[1], if1.dct_in);
    p1 <= p0;
  end
  assign if1.in_valid  = vld[1];
  assign if1.in_data   = din[1];
  assign if1.out_ready = ordy[1];
  assign if1.dct_out   = p1;

  function automatic logic o_in_ready(input int s);  return s != 0 ? if1.in_ready  : if0.in_ready;  endfunction
  function automatic logic o_out_valid(input int s); return s != 0 ? if1.out_valid : if0.out_valid; endfunction
  function automatic logic o_busy(input int s);      return s != 0 ? if1.busy      : if0.busy;      endfunction
  function automatic logic o_done(input int s);      return s != 0 ? if1.done      : if0.done;      endfunction
  function automatic row_t o_out_data(input int s);  return s != 0 ? if1.out_data  : if0.out_data;  endfunction
  function automatic row_t o_dct_in(input int s);    return s != 0 ? if1.dct_in    : if0.dct_in;    endfunction

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, act, exp);
  endtask

  function automatic row_t pack_row(input blk_t a, input int r);
    row_t v;
    for (int k = 0; k < 8; k++) v[k*N +: N] = a[r][k];
    return v;
  endfunction

  row_t exp_q [$];

  // Reference 2-D transform: stub on every row, then on every column
  task automatic push_expect(input blk_t a, input logic [1:0] m);
    blk_t b;
    row_t v;
    b = a;
    for (int r = 0; r < 8; r++) begin
      v = stub_f(m, pack_row(b, r));
      for (int k = 0; k < 8; k++) b[r][k] = v[k*N +: N];
    end
    for (int c = 0; c < 8; c++) begin
      for (int k = 0; k < 8; k++) v[k*N +: N] = b[k][c];
      v = stub_f(m, v);
      for (int k = 0; k < 8; k++) b[k][c] = v[k*N +: N];
    end
    for (int r = 0; r < 8; r++) exp_q.push_back(pack_row(b, r));
  endtask

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int sel       = 0;
  int acc_cnt   = 0;
  int acc7_edge = 0;
  int done_cnt  = 0;
  bit ov_prev   = 1'b0;

  // Monitor: input accepts, output latency, scoreboard compare, done pulses
  always @(negedge clk) begin
    if (rst_n) begin
      if (vld[sel] && o_in_ready(sel)) begin
        if (acc_cnt % 8 == 7) acc7_edge = cyc + 1;
        acc_cnt++;
      end
      if (o_out_valid(sel) && !ov_prev) begin
        check("latency", VW'(cyc - acc7_edge), VW'(16 * (sel != 0 ? 3 : 1)));
        check("in_ready_in_out", VW'(o_in_ready(sel)), VW'(0));
      end
      if (o_out_valid(sel) && ordy[sel]) begin
        check("row_expected", VW'(exp_q.size() != 0), VW'(1));
        if (exp_q.size() != 0) check("out_row", o_out_data(sel), exp_q.pop_front());
      end
      if (o_done(sel)) begin
        done_cnt++;
        check("busy_at_done", VW'(o_busy(sel)), VW'(0));
        check("in_ready_at_done", VW'(o_in_ready(sel)), VW'(1));
      end
      ov_prev = o_out_valid(sel);
    end else begin
      ov_prev = 1'b0;
    end
  end

  // Output backpressure: pattern 1,0,0 repeating when bp is set
  bit bp    = 1'b0;
  int bp_ph = 0;
  initial begin
    ordy[0] = 1'b1;
    ordy[1] = 1'b1;
    forever begin
      @(posedge clk); #1;
      bp_ph   = (bp_ph + 1) % 3;
      ordy[0] = bp ? (bp_ph == 0) : 1'b1;
      ordy[1] = bp ? (bp_ph == 0) : 1'b1;
    end
  end

  task automatic send_block(input int s, input blk_t a, input bit keep);
    int r;
    int guard;
    r     = 0;
    guard = 0;
    while (r < 8 && guard < 4000) begin
      @(posedge clk); #1;
      vld[s] = 1'b1;
      din[s] = pack_row(a, r);
      @(negedge clk);
      if (o_in_ready(s)) r++;
      guard++;
    end
    check("send_rows", VW'(r), VW'(8));
    if (!keep) begin
      @(posedge clk); #1;
      vld[s] = 1'b0;
    end
  endtask

  task automatic wait_drain(input int budget);
    int t;
    t = 0;
    while ((exp_q.size() != 0 || o_out_valid(sel)) && t < budget) begin
      @(negedge clk);
      t++;
    end
    check("drain", VW'(exp_q.size()), VW'(0));
    repeat (2) @(negedge clk);
  endtask

  blk_t a, b2;
  int   t;

  initial begin
    vld[0] = 1'b0; vld[1] = 1'b0;
    din[0] = '0;   din[1] = '0;
    mode[0] = 2'd0; mode[1] = 2'd2;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      check("rst_in_ready", VW'(o_in_ready(s)), VW'(1));
      check("rst_out_valid", VW'(o_out_valid(s)), VW'(0));
      check("rst_busy", VW'(o_busy(s)), VW'(0));
      check("rst_done", VW'(o_done(s)), VW'(0));
      check("rst_dct_in", o_dct_in(s), VW'(0));
    end
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Identity, ramp input, latency 0
    sel = 0; mode[0] = 2'd0; done_cnt = 0;
    for (int r = 0; r < 8; r++) for (int c = 0; c < 8; c++) a[r][c] = N'(8 * r + c);
    push_expect(a, mode[0]);
    send_block(0, a, 1'b0);
    wait_drain(500);
    check("done_once_ident", VW'(done_cnt), VW'(1));

    // Element-0-only stub exposes any row/column mix-up
    mode[0] = 2'd1; done_cnt = 0;
    for (int r = 0; r < 8; r++) for (int c = 0; c < 8; c++) a[r][c] = N'(8 * r + c + 1);
    push_expect(a, mode[0]);
    check("transpose_model_row0", exp_q[0], VW'(1));
    send_block(0, a, 1'b0);
    wait_drain(500);
    check("done_once_transp", VW'(done_cnt), VW'(1));

    // +3 stub, negative samples, latency 2
    sel = 1; done_cnt = 0; acc_cnt = 0;
    for (int r = 0; r < 8; r++) for (int c = 0; c < 8; c++) a[r][c] = 16'hFF9C;
    push_expect(a, mode[1]);
    send_block(1, a, 1'b0);
    wait_drain(1000);
    check("done_once_lat2", VW'(done_cnt), VW'(1));

    // Backpressure with in_valid held high through the passes
    sel = 0; mode[0] = 2'd0; done_cnt = 0; acc_cnt = 0; bp = 1'b1;
    for (int r = 0; r < 8; r++) for (int c = 0; c < 8; c++) a[r][c] = N'($urandom);
    push_expect(a, mode[0]);
    send_block(0, a, 1'b1);
    t = 0;
    while (!o_done(0) && t < 3000) begin
      @(posedge clk); #1;
      t++;
    end
    vld[0] = 1'b0;
    check("bp_done_seen", VW'(o_done(0)), VW'(1));
    wait_drain(500);
    check("bp_accepts", VW'(acc_cnt), VW'(8));
    check("done_once_bp", VW'(done_cnt), VW'(1));
    bp = 1'b0;

    // Reset mid column pass discards the block
    for (int r = 0; r < 8; r++) for (int c = 0; c < 8; c++) a[r][c] = N'($urandom);
    send_block(0, a, 1'b0);
    repeat (11) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("midrst_in_ready", VW'(o_in_ready(0)), VW'(1));
    check("midrst_out_valid", VW'(o_out_valid(0)), VW'(0));
    check("midrst_busy", VW'(o_busy(0)), VW'(0));
    check("midrst_dct_in", o_dct_in(0), VW'(0));
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    acc_cnt = 0; done_cnt = 0;
    for (int r = 0; r < 8; r++) for (int c = 0; c < 8; c++) a[r][c] = N'($urandom);
    push_expect(a, mode[0]);
    send_block(0, a, 1'b0);
    wait_drain(500);
    check("done_once_postrst", VW'(done_cnt), VW'(1));

    // Back-to-back blocks, valid and ready always high
    done_cnt = 0;
    for (int r = 0; r < 8; r++) for (int c = 0; c < 8; c++) begin
      a[r][c]  = N'($urandom);
      b2[r][c] = N'($urandom);
    end
    push_expect(a, mode[0]);
    send_block(0, a, 1'b1);
    push_expect(b2, mode[0]);
    send_block(0, b2, 1'b0);
    wait_drain(1000);
    check("done_b2b", VW'(done_cnt), VW'(2));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
